instruction_pointer_ras: RTL and testbench
==========================================

Name: instruction_pointer_ras

Overview:
- Next-generation fetch instruction pointer, parametrised in address width.
- Adds prioritised next-PC selection: reset, trap, redirect, return, hold, increment.
- Adds a circular return-address stack (RAS) for call/return prediction.
- Sits at the front of the fetch stage; drives the fetch address and the link address to decode and writeback.

Parameters:
- p_AddressWidth, 32, width of all address ports.
- p_ResetAddress, 32'h0040_0000, IP value after reset.
- p_TrapVector, 32'h0040_0100, IP value loaded on trap.
- p_StackDepth, 8, RAS entries; power of two, ≥2 (elaboration-time $error otherwise).

Ports:
- i_Clock  in  1  clock, rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Stall  in  1  hold IP; suppress push/pop.
- i_Stride  in  1  0: +2 bytes (compressed), 1: +4 bytes.
- i_Redirect  in  1  load i_RedirectAddress (branch/jump resolve).
- i_RedirectAddress  in  p_AddressWidth  redirect target.
- i_Trap  in  1  load p_TrapVector.
- i_Call  in  1  current instruction is a call; push link address.
- i_Return  in  1  current instruction is a return; pop and predict.
- o_Address  out  p_AddressWidth  current IP (registered).
- o_LinkAddress  out  p_AddressWidth  o_Address + stride (combinational).
- o_PredictedReturn  out  p_AddressWidth  current RAS top; 0 when empty.
- o_StackCount  out  $clog2(p_StackDepth)+1  valid RAS entries.
- o_Underflow  out  1  one-cycle registered pulse on a pop of an empty stack.

Behaviour:
- Reset: i_Reset on a rising edge sets o_Address = p_ResetAddress, o_StackCount = 0, RAS pointer = 0, o_Underflow = 0.
- Reset overrides everything, including i_Stall. This is a deliberate change from the predecessor, whose reset was gated by stall.
- Next-IP priority, highest first:
  - reset → p_ResetAddress
  - trap → p_TrapVector
  - redirect → {i_RedirectAddress[W-1:1], 1'b0}
  - return with count > 0 and no stall → RAS top
  - stall → hold
  - otherwise → o_Address + stride
- Trap and redirect override stall. Return does not.
- Address arithmetic is modulo 2^p_AddressWidth; wrap at max address is silent.
- Latency: o_Address updates one cycle after inputs are sampled. o_LinkAddress and o_PredictedReturn reflect the current state and i_Stride combinationally.
- RAS operations are enabled when not stalled and not trapping and not resetting (call pairs with redirect under stall):
  - Push (i_Call, no i_Return, enabled): write o_LinkAddress at the pointer, pointer+1, count saturates at p_StackDepth. When full, the oldest entry is overwritten (circular).
  - Pop (i_Return, no i_Call, enabled, count > 0): pointer−1, count−1.
  - Pop on empty: no IP change from the RAS (falls through to the increment rule), pointer/count unchanged, o_Underflow = 1 next cycle.
  - Call and return together (enabled): next IP = old top, unless redirect is also asserted. The top entry is replaced in place by o_LinkAddress; count unchanged. If count = 0, this acts as a push with no underflow.
- Trap leaves the RAS untouched. Redirect alone does not touch the RAS.
- Pointer wraps modulo p_StackDepth.
- o_Underflow is low in every cycle other than the one following an empty pop.

Decomposition:
- Package ip_pkg:
  - stride_t enum (STRIDE_2, STRIDE_4)
  - next_source_t enum (SRC_RESET, SRC_TRAP, SRC_REDIRECT, SRC_RETURN, SRC_HOLD, SRC_INCREMENT)
  - stride_bytes() function
- Sub-module return_address_stack: circular buffer with pointer, saturating count, push/pop/replace ports, top and underflow outputs; parametrised by width and depth.
- Top level: priority mux, IP register, link adder.

Test Plan:
1. Reset then 3 cycles, stride 0 → IP 0x00400000, 0x00400002, 0x00400004, 0x00400006; link = IP+2.
2. Stall with i_Reset=1 at IP 0x00400006 → IP = 0x00400000 next cycle (reset beats stall). Stall with trap → IP = 0x00400100.
3. Call + redirect 0x10000000 at IP 0x00400000, stride 1 → IP 0x10000000, count 1, top 0x00400004. Return at 0x10000000 → IP 0x00400004, count 0.
4. Depth 8: nine calls with distinct links L0..L8, then eight returns → IPs L8 down to L1. Ninth return → IP increments, o_Underflow pulses once, count stays 0.
5. Return while stalled → IP holds, count unchanged. Redirect to 0x20000003 while stalled → IP 0x20000002.
6. Call + return together with count 2, top T → IP = T, count 2, new top = previous o_LinkAddress. Trap mid-sequence → count unchanged.

Source files
------------

// File: rtl/instruction_pointer_ras_pkg.sv
// Shared types and helpers for the fetch instruction pointer and its
// return-address stack.
package ip_pkg;

  // Fetch stride selected by i_Stride: compressed (2 bytes) or full (4 bytes).
  typedef enum logic {
    STRIDE_2 = 1'b0,
    STRIDE_4 = 1'b1
  } stride_t;

  // Source of the next instruction pointer, listed highest priority first.
  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_RETURN,
    SRC_HOLD,
    SRC_INCREMENT
  } next_source_t;

  // Byte distance to the next sequential instruction.
  function automatic logic [2:0] stride_bytes(input stride_t stride);
    return (stride == STRIDE_4) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/instruction_pointer_ras_return_address_stack.sv
// Circular return-address stack. Push past full overwrites the oldest entry,
// count saturates at the depth, and a pop of an empty stack produces a
// one-cycle underflow pulse instead of moving the pointer.
module return_address_stack
  import ip_pkg::*;
#(
  parameter int unsigned p_Width = 32,
  parameter int unsigned p_Depth = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Push,
  input  logic                       i_Pop,
  input  logic                       i_Replace,
  input  logic [p_Width-1:0]         i_Data,
  output logic [p_Width-1:0]         o_Top,
  output logic [$clog2(p_Depth):0]   o_Count,
  output logic                       o_Underflow
);

  localparam int unsigned PtrWidth   = $clog2(p_Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  if (p_Depth < 2 || (p_Depth & (p_Depth - 1)) != 0) begin : g_bad_depth
    $error("return_address_stack: p_Depth must be a power of two and at least 2");
  end

  logic [PtrWidth-1:0]   ptr_q, ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [p_Width-1:0]    stack_q [p_Depth];

  logic                  wr_en;
  logic [PtrWidth-1:0]   wr_idx;
  logic [PtrWidth-1:0]   top_idx;
  logic                  empty;

  // The pointer addresses the next free slot; the top lives one below it.
  assign top_idx = ptr_q - PtrWidth'(1);
  assign empty   = (count_q == '0);

  // Next pointer/count/underflow and the write port for push or replace.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    if (i_Replace && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (i_Push || i_Replace) begin
      // A replace on an empty stack behaves exactly like a push.
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PtrWidth'(1);
      if (count_q != CountWidth'(p_Depth)) begin
        count_d = count_q + CountWidth'(1);
      end
    end else if (i_Pop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        ptr_d   = ptr_q - PtrWidth'(1);
        count_d = count_q - CountWidth'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_Clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (i_Reset) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge i_Clock) begin
    // NOTE: the storage array has no reset; entries are only ever read while
    // the count says they are valid, and leaving it unreset keeps it a plain RAM.
    if (wr_en) begin
      stack_q[wr_idx] <= i_Data;
    end
  end

  assign o_Top       = empty ? '0 : stack_q[top_idx];
  assign o_Count     = count_q;
  assign o_Underflow = underflow_q;

endmodule

// File: rtl/instruction_pointer_ras.sv
// Fetch instruction pointer with prioritised next-PC selection and a
// return-address stack for call/return prediction.
module instruction_pointer_ras
  import ip_pkg::*;
#(
  parameter int unsigned               p_AddressWidth = 32,
  parameter logic [p_AddressWidth-1:0] p_ResetAddress = 32'h0040_0000,
  parameter logic [p_AddressWidth-1:0] p_TrapVector   = 32'h0040_0100,
  parameter int unsigned               p_StackDepth   = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Stall,
  input  logic                          i_Stride,
  input  logic                          i_Redirect,
  input  logic [p_AddressWidth-1:0]     i_RedirectAddress,
  input  logic                          i_Trap,
  input  logic                          i_Call,
  input  logic                          i_Return,
  output logic [p_AddressWidth-1:0]     o_Address,
  output logic [p_AddressWidth-1:0]     o_LinkAddress,
  output logic [p_AddressWidth-1:0]     o_PredictedReturn,
  output logic [$clog2(p_StackDepth):0] o_StackCount,
  output logic                          o_Underflow
);

  logic [p_AddressWidth-1:0]     addr_q, addr_d;
  logic [p_AddressWidth-1:0]     link_addr;
  logic [p_AddressWidth-1:0]     ras_top;
  logic [$clog2(p_StackDepth):0] ras_count;
  logic                          ras_empty;
  logic                          ras_enable;
  logic                          ras_push, ras_pop, ras_replace;
  stride_t                       stride;
  next_source_t                  next_src;

  assign stride    = stride_t'(i_Stride);
  assign link_addr = addr_q + p_AddressWidth'(stride_bytes(stride));
  assign ras_empty = (ras_count == '0);

  // Stack traffic only happens on an instruction that actually advances:
  // no stall, no trap, no reset.
  assign ras_enable  = !i_Stall && !i_Trap && !i_Reset;
  assign ras_push    = ras_enable && i_Call && !i_Return;
  assign ras_pop     = ras_enable && i_Return && !i_Call;
  assign ras_replace = ras_enable && i_Call && i_Return;

  return_address_stack #(
    .p_Width (p_AddressWidth),
    .p_Depth (p_StackDepth)
  ) u_ras (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Push      (ras_push),
    .i_Pop       (ras_pop),
    .i_Replace   (ras_replace),
    .i_Data      (link_addr),
    .o_Top       (ras_top),
    .o_Count     (ras_count),
    .o_Underflow (o_Underflow)
  );

  // Priority selection of the next IP source, then the matching address.
  always_comb begin
    next_src = SRC_INCREMENT;
    if (i_Reset) begin
      next_src = SRC_RESET;
    end else if (i_Trap) begin
      next_src = SRC_TRAP;
    end else if (i_Redirect) begin
      next_src = SRC_REDIRECT;
    end else if (i_Return && !ras_empty && !i_Stall) begin
      next_src = SRC_RETURN;
    end else if (i_Stall) begin
      next_src = SRC_HOLD;
    end

    case (next_src)
      SRC_RESET:     addr_d = p_ResetAddress;
      SRC_TRAP:      addr_d = p_TrapVector;
      SRC_REDIRECT:  addr_d = {i_RedirectAddress[p_AddressWidth-1:1], 1'b0};
      SRC_RETURN:    addr_d = ras_top;
      SRC_HOLD:      addr_d = addr_q;
      SRC_INCREMENT: addr_d = link_addr;
      default:       addr_d = addr_q;
    endcase
  end

  // IP register; reset is folded into the selection above so it beats stall.
  always_ff @(posedge i_Clock) begin
    addr_q <= addr_d;
  end

  assign o_Address         = addr_q;
  assign o_LinkAddress     = link_addr;
  assign o_PredictedReturn = ras_top;
  assign o_StackCount      = ras_count;

endmodule

// File: tb/tb_instruction_pointer_ras.sv
// Self-checking bench for instruction_pointer_ras: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_instruction_pointer_ras;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;
  localparam logic [31:0] RST_ADDR  = 32'h0040_0000;
  localparam logic [31:0] TRAP_ADDR = 32'h0040_0100;

  logic        clk = 1'b0;
  logic        rst, stall, stride, redir, trap, call, ret;
  logic [31:0] raddr;
  logic [31:0] o_addr, o_link, o_pred;
  logic [3:0]  o_count;
  logic        o_uf;

  always #5 clk = ~clk;

  instruction_pointer_ras #(
    .p_AddressWidth (W),
    .p_ResetAddress (RST_ADDR),
    .p_TrapVector   (TRAP_ADDR),
    .p_StackDepth   (D)
  ) dut (
    .i_Clock           (clk),
    .i_Reset           (rst),
    .i_Stall           (stall),
    .i_Stride          (stride),
    .i_Redirect        (redir),
    .i_RedirectAddress (raddr),
    .i_Trap            (trap),
    .i_Call            (call),
    .i_Return          (ret),
    .o_Address         (o_addr),
    .o_LinkAddress     (o_link),
    .o_PredictedReturn (o_pred),
    .o_StackCount      (o_count),
    .o_Underflow       (o_uf)
  );

  // Reference model: IP as a number, the stack as a bounded queue (back = top).
  logic [31:0] m_ip;
  logic [31:0] m_q[$];
  logic        m_uf;
  bit          m_valid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_top();
    return (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
  endfunction

  task automatic model_step(input logic r, s, st, rd, input logic [31:0] ra,
                            input logic tp, c, rt);
    logic [31:0] link, nip;
    bit en;
    link = m_ip + (st ? 32'd4 : 32'd2);
    en   = !r && !s && !tp;
    if (r) begin
      m_ip = RST_ADDR;
      m_q.delete();
      m_uf = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_uf = en && rt && !c && (m_q.size() == 0);
      if (tp)                            nip = TRAP_ADDR;
      else if (rd)                       nip = {ra[31:1], 1'b0};
      else if (rt && m_q.size() > 0 && !s) nip = m_top();
      else if (s)                        nip = m_ip;
      else                               nip = link;
      if (en) begin
        if (c && !rt) begin
          m_q.push_back(link);
          if (m_q.size() > D) void'(m_q.pop_front());
        end else if (rt && !c) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (c && rt) begin
          if (m_q.size() > 0) m_q[m_q.size()-1] = link;
          else m_q.push_back(link);
        end
      end
      m_ip = nip;
    end
  endtask

  // One clock: drive, check combinational outputs, advance, check registered state.
  task automatic cyc(input logic r, s, st, rd, input logic [31:0] ra,
                     input logic tp, c, rt);
    rst = r; stall = s; stride = st; redir = rd; raddr = ra;
    trap = tp; call = c; ret = rt;
    #1;
    if (m_valid) begin
      check("link", o_link, m_ip + (st ? 32'd4 : 32'd2));
      check("pred", o_pred, m_top());
    end
    model_step(r, s, st, rd, ra, tp, c, rt);
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("ip", o_addr, m_ip);
      check("underflow", 32'(o_uf), 32'(m_uf));
      check("count", 32'(o_count), 32'(m_q.size()));
    end
  endtask

  logic [31:0] links [9];
  logic [31:0] saved;

  initial begin
    rst = 1'b0; stall = 1'b0; stride = 1'b0; redir = 1'b0;
    raddr = '0; trap = 1'b0; call = 1'b0; ret = 1'b0;
    @(posedge clk);
    #1;

    // Reset then sequential compressed fetch.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("tp1_reset_ip", o_addr, 32'h0040_0000);
    check("tp1_reset_count", 32'(o_count), 32'd0);
    check("tp1_reset_uf", 32'(o_uf), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp1_ip3", o_addr, 32'h0040_0006);
    check("tp1_link", o_link, 32'h0040_0008);

    // Reset beats stall; trap beats stall.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    check("tp2_reset_stall", o_addr, 32'h0040_0000);
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    check("tp2_trap_stall", o_addr, 32'h0040_0100);

    // Call + redirect then return.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h1000_0000, 0, 1, 0);
    check("tp3_call_ip", o_addr, 32'h1000_0000);
    check("tp3_call_count", 32'(o_count), 32'd1);
    check("tp3_call_top", o_pred, 32'h0040_0004);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    check("tp3_ret_ip", o_addr, 32'h0040_0004);
    check("tp3_ret_count", 32'(o_count), 32'd0);

    // Overflow the stack with nine calls, unwind it, then underflow.
    for (int i = 0; i < 9; i++) begin
      links[i] = m_ip + 32'd4;
      cyc(0, 0, 1, 1, 32'h3000_0000 + 32'(i) * 32'h100, 0, 1, 0);
    end
    check("tp4_full_count", 32'(o_count), 32'd8);
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 1);
      check("tp4_ret_ip", o_addr, links[8-j]);
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    check("tp4_uf_ip", o_addr, links[1] + 32'd4);
    check("tp4_uf_pulse", 32'(o_uf), 32'd1);
    check("tp4_uf_count", 32'(o_count), 32'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    check("tp4_uf_drop", 32'(o_uf), 32'd0);

    // Return while stalled holds; redirect under stall is aligned.
    cyc(0, 0, 1, 1, 32'h4000_0000, 0, 1, 0);
    saved = o_addr;
    cyc(0, 1, 1, 0, 0, 0, 0, 1);
    check("tp5_stall_ret_ip", o_addr, saved);
    check("tp5_stall_ret_count", 32'(o_count), 32'd1);
    cyc(0, 1, 1, 1, 32'h2000_0003, 0, 0, 0);
    check("tp5_stall_redir", o_addr, 32'h2000_0002);

    // Call + return together replaces the top; trap leaves the stack alone.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h5000_0000, 0, 1, 0);
    cyc(0, 0, 1, 1, 32'h6000_0000, 0, 1, 0);
    saved = o_pred;
    links[0] = o_addr + 32'd4;
    cyc(0, 0, 1, 0, 0, 0, 1, 1);
    check("tp6_cr_ip", o_addr, saved);
    check("tp6_cr_count", 32'(o_count), 32'd2);
    check("tp6_cr_top", o_pred, links[0]);
    cyc(0, 0, 1, 0, 0, 1, 1, 0);
    check("tp6_trap_ip", o_addr, TRAP_ADDR);
    check("tp6_trap_count", 32'(o_count), 32'd2);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 15),
          1'($urandom),
          ($urandom_range(0, 99) < 20),
          $urandom,
          ($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
